miter_lockstep_cmp: RTL and testbench

//  Run-time gold-vs-gate lockstep comparator: the clocked, multi-channel successor to our single-bit EQY miter.

---
 rtl/miter_lockstep_cmp.sv | 162 ++++++++++++++++
 tb/tb_miter_lockstep_cmp.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miter_lockstep_cmp.sv
// Clocked gold-vs-gate lockstep comparator: NCH channels, per-bit care mask,
// gold aligned by GOLD_LAT stages, saturating counters and first-failure capture.
module miter_lockstep_cmp #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned NCH          = 4,
   parameter int unsigned GOLD_LAT     = 2,
   parameter int unsigned CNT_W        = 16,
   parameter bit          STOP_ON_FAIL = 1'b1
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    start,
   input  logic                                    stop,
   input  logic                                    gold_valid,
   input  logic [NCH*WIDTH-1:0]                    gold_in,
   input  logic [NCH*WIDTH-1:0]                    care_mask,
   input  logic                                    gate_valid,
   input  logic [NCH*WIDTH-1:0]                    gate_in,
   output logic [NCH-1:0]                          mismatch_ch,
   output logic                                    align_err,
   output logic                                    err,
   output logic [CNT_W-1:0]                        cmp_cnt,
   output logic [CNT_W-1:0]                        err_cnt,
   output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] first_ch,
   output logic [CNT_W-1:0]                        first_beat,
   output logic                                    busy,
   output logic                                    done,
   output logic                                    pass
);

   localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned DW   = NCH * WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAIL} state_t;

   state_t            r_state, w_state_nxt;
   logic              w_g_v;
   logic [DW-1:0]     w_g_d, w_g_m;
   logic [NCH-1:0]    w_ch_bad;
   logic [CH_W-1:0]   w_first_bad;
   logic              w_active, w_cmp, w_align, w_fail;

   logic [NCH-1:0]    r_mismatch_ch;
   logic              r_align_err, r_err;
   logic [CNT_W-1:0]  r_cmp_cnt, r_err_cnt, r_first_beat;
   logic [CH_W-1:0]   r_first_ch;

   generate
      if (GOLD_LAT == 0) begin : g_nodly
         assign w_g_v = gold_valid;
         assign w_g_d = gold_in;
         assign w_g_m = care_mask;
      end else begin : g_dly
         logic [GOLD_LAT-1:0] r_dl_v;
         logic [DW-1:0]       r_dl_d [GOLD_LAT];
         logic [DW-1:0]       r_dl_m [GOLD_LAT];

         // start flushes every in-flight valid so a new window sees only its own beats
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_dl_v <= '0;
               for (int unsigned i = 0; i < GOLD_LAT; i++) begin
                  r_dl_d[i] <= '0;
                  r_dl_m[i] <= '0;
               end
            end else begin
               r_dl_v[0] <= gold_valid & ~start;
               r_dl_d[0] <= gold_in;
               r_dl_m[0] <= care_mask;
               for (int unsigned i = 1; i < GOLD_LAT; i++) begin
                  r_dl_v[i] <= r_dl_v[i-1] & ~start;
                  r_dl_d[i] <= r_dl_d[i-1];
                  r_dl_m[i] <= r_dl_m[i-1];
               end
            end
         end

         assign w_g_v = r_dl_v[GOLD_LAT-1];
         assign w_g_d = r_dl_d[GOLD_LAT-1];
         assign w_g_m = r_dl_m[GOLD_LAT-1];
      end
   endgenerate

   always_comb begin
      w_ch_bad    = '0;
      w_first_bad = '0;
      for (int unsigned c = 0; c < NCH; c++)
         w_ch_bad[c] = |((w_g_d[c*WIDTH +: WIDTH] ^ gate_in[c*WIDTH +: WIDTH]) & w_g_m[c*WIDTH +: WIDTH]);
      for (int unsigned c = NCH; c > 0; c--)
         if (w_ch_bad[c-1]) w_first_bad = CH_W'(c - 1);
   end

   assign w_active = (r_state == S_RUN) & ~start;
   assign w_cmp    = w_active & w_g_v & gate_valid;
   assign w_align  = w_active & (w_g_v ^ gate_valid);
   assign w_fail   = w_align | (w_cmp & (|w_ch_bad));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      pass        = 1'b0;
      if (start) begin
         w_state_nxt = S_RUN;
      end else if (r_state == S_RUN) begin
         if (stop)                        w_state_nxt = S_DONE;
         else if (w_fail && STOP_ON_FAIL) w_state_nxt = S_FAIL;
      end
      busy = (r_state == S_RUN);
      done = (r_state == S_DONE) || (r_state == S_FAIL);
      pass = done & ~r_err;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mismatch_ch <= '0;
         r_align_err   <= 1'b0;
         r_err         <= 1'b0;
         r_cmp_cnt     <= '0;
         r_err_cnt     <= '0;
         r_first_ch    <= '0;
         r_first_beat  <= '0;
      end else if (start) begin
         r_mismatch_ch <= '0;
         r_align_err   <= 1'b0;
         r_err         <= 1'b0;
         r_cmp_cnt     <= '0;
         r_err_cnt     <= '0;
         r_first_ch    <= '0;
         r_first_beat  <= '0;
      end else begin
         if (w_cmp) begin
            r_mismatch_ch <= w_ch_bad;
            if (r_cmp_cnt != '1) r_cmp_cnt <= r_cmp_cnt + 1'b1;
         end
         // r_err still low marks this as the window's first failing beat
         if (w_fail) begin
            r_err <= 1'b1;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            if (!r_err) begin
               r_first_ch   <= w_align ? '0 : w_first_bad;
               r_first_beat <= r_cmp_cnt;
            end
         end
         if (w_align) r_align_err <= 1'b1;
      end
   end

   assign mismatch_ch = r_mismatch_ch;
   assign align_err   = r_align_err;
   assign err         = r_err;
   assign cmp_cnt     = r_cmp_cnt;
   assign err_cnt     = r_err_cnt;
   assign first_ch    = r_first_ch;
   assign first_beat  = r_first_beat;

endmodule

// File: tb/tb_miter_lockstep_cmp.sv
// Bench for miter_lockstep_cmp: four parameterisations share one stimulus stream
// and are checked against a beat-level model of the comparator rules.
module tb_miter_lockstep_cmp;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int DW = 32;

   logic clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, gv = 1'b0, tv = 1'b0;
   logic [DW-1:0] gd = '0, gm = '0, td = '0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   logic [3:0]  mm_a, mm_b, mm_c, mm_d;
   logic        al_a, al_b, al_c, al_d, er_a, er_b, er_c, er_d;
   logic        bz_a, bz_b, bz_c, bz_d, dn_a, dn_b, dn_c, dn_d, ps_a, ps_b, ps_c, ps_d;
   logic [1:0]  fc_a, fc_b, fc_c, fc_d;
   logic [15:0] cc_a, cc_b, cc_d, ec_a, ec_b, ec_d, fb_a, fb_b, fb_d;
   logic [3:0]  cc_c, ec_c, fb_c;
   logic [58:0] obs [4];

   miter_lockstep_cmp #(.WIDTH(8), .NCH(4), .GOLD_LAT(2), .CNT_W(16), .STOP_ON_FAIL(1'b1)) u_a (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .gold_valid(gv), .gold_in(gd), .care_mask(gm),
      .gate_valid(tv), .gate_in(td), .mismatch_ch(mm_a), .align_err(al_a), .err(er_a), .cmp_cnt(cc_a),
      .err_cnt(ec_a), .first_ch(fc_a), .first_beat(fb_a), .busy(bz_a), .done(dn_a), .pass(ps_a));
   miter_lockstep_cmp #(.WIDTH(8), .NCH(4), .GOLD_LAT(2), .CNT_W(16), .STOP_ON_FAIL(1'b0)) u_b (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .gold_valid(gv), .gold_in(gd), .care_mask(gm),
      .gate_valid(tv), .gate_in(td), .mismatch_ch(mm_b), .align_err(al_b), .err(er_b), .cmp_cnt(cc_b),
      .err_cnt(ec_b), .first_ch(fc_b), .first_beat(fb_b), .busy(bz_b), .done(dn_b), .pass(ps_b));
   miter_lockstep_cmp #(.WIDTH(8), .NCH(4), .GOLD_LAT(2), .CNT_W(4), .STOP_ON_FAIL(1'b1)) u_c (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .gold_valid(gv), .gold_in(gd), .care_mask(gm),
      .gate_valid(tv), .gate_in(td), .mismatch_ch(mm_c), .align_err(al_c), .err(er_c), .cmp_cnt(cc_c),
      .err_cnt(ec_c), .first_ch(fc_c), .first_beat(fb_c), .busy(bz_c), .done(dn_c), .pass(ps_c));
   miter_lockstep_cmp #(.WIDTH(8), .NCH(4), .GOLD_LAT(0), .CNT_W(16), .STOP_ON_FAIL(1'b0)) u_d (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .gold_valid(gv), .gold_in(gd), .care_mask(gm),
      .gate_valid(tv), .gate_in(td), .mismatch_ch(mm_d), .align_err(al_d), .err(er_d), .cmp_cnt(cc_d),
      .err_cnt(ec_d), .first_ch(fc_d), .first_beat(fb_d), .busy(bz_d), .done(dn_d), .pass(ps_d));

   assign obs[0] = {mm_a, al_a, er_a, cc_a, ec_a, fc_a, fb_a, bz_a, dn_a, ps_a};
   assign obs[1] = {mm_b, al_b, er_b, cc_b, ec_b, fc_b, fb_b, bz_b, dn_b, ps_b};
   assign obs[2] = {mm_c, al_c, er_c, 12'd0, cc_c, 12'd0, ec_c, fc_c, 12'd0, fb_c, bz_c, dn_c, ps_c};
   assign obs[3] = {mm_d, al_d, er_d, cc_d, ec_d, fc_d, fb_d, bz_d, dn_d, ps_d};

   // Reference model: one entry per DUT configuration, updated once per clock edge.
   int  cfg_lat [4] = '{2, 2, 2, 0};
   bit  cfg_sof [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   int  cfg_max [4] = '{65535, 65535, 15, 65535};
   int  m_cmp [4], m_errc [4], m_fch [4], m_fb [4];
   bit  m_run [4], m_fin [4], m_al [4], m_err [4];
   logic [3:0] m_mm [4];
   bit  h_v [2];
   logic [DW-1:0] h_d [2], h_m [2];

   function automatic logic [58:0] expv(input int k);
      return {m_mm[k], m_al[k], m_err[k], 16'(m_cmp[k]), 16'(m_errc[k]), 2'(m_fch[k]),
              16'(m_fb[k]), m_run[k], m_fin[k], m_fin[k] & ~m_err[k]};
   endfunction

   task automatic model_clear(input int k);
      m_cmp[k] = 0; m_errc[k] = 0; m_fch[k] = 0; m_fb[k] = 0;
      m_al[k] = 1'b0; m_err[k] = 1'b0; m_mm[k] = '0;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         model_clear(k);
         m_run[k] = 1'b0; m_fin[k] = 1'b0;
      end
      for (int j = 0; j < 2; j++) begin
         h_v[j] = 1'b0; h_d[j] = '0; h_m[j] = '0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 4; k++) begin
         bit av, both, one, failb;
         logic [DW-1:0] ad, am, x;
         logic [3:0] bad;
         int lo, prev;
         if (cfg_lat[k] == 0) begin
            av = gv; ad = gd; am = gm;
         end else begin
            av = h_v[cfg_lat[k]-1]; ad = h_d[cfg_lat[k]-1]; am = h_m[cfg_lat[k]-1];
         end
         if (start) begin
            model_clear(k);
            m_run[k] = 1'b1; m_fin[k] = 1'b0;
         end else if (m_run[k]) begin
            x = (ad ^ td) & am;
            bad = '0; lo = -1;
            for (int c = 0; c < N; c++) begin
               if (x[c*W +: W] != 0) begin
                  bad[c] = 1'b1;
                  if (lo < 0) lo = c;
               end
            end
            both = av && tv;
            one = (av != tv);
            failb = one || (both && bad != 0);
            prev = m_cmp[k];
            if (both) begin
               m_mm[k] = bad;
               if (m_cmp[k] < cfg_max[k]) m_cmp[k]++;
            end
            if (failb) begin
               if (!m_err[k]) begin
                  m_fch[k] = one ? 0 : lo;
                  m_fb[k] = prev;
               end
               m_err[k] = 1'b1;
               if (m_errc[k] < cfg_max[k]) m_errc[k]++;
               if (one) m_al[k] = 1'b1;
            end
            if (stop || (failb && cfg_sof[k])) begin
               m_run[k] = 1'b0; m_fin[k] = 1'b1;
            end
         end
      end
      h_v[1] = h_v[0]; h_d[1] = h_d[0]; h_m[1] = h_m[0];
      h_v[0] = gv; h_d[0] = gd; h_m[0] = gm;
      if (start) begin
         h_v[0] = 1'b0; h_v[1] = 1'b0;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst) model_step();
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; cyc(); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; cyc(); stop = 1'b0;
   endtask

   task automatic run_stream(input int nb, input int lag, input int fbeat,
                             input logic [DW-1:0] fx, input logic [DW-1:0] mclr);
      logic [DW-1:0] dq[$];
      for (int i = 0; i < nb + lag; i++) begin
         if (i < nb) begin
            gv = 1'b1; gd = $urandom; gm = (i == fbeat) ? ~mclr : '1;
            dq.push_back(gd);
         end else gv = 1'b0;
         if (i >= lag) begin
            tv = 1'b1; td = dq.pop_front();
            if (i - lag == fbeat) td = td ^ fx;
         end else tv = 1'b0;
         cyc();
      end
      gv = 1'b0; tv = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs[k] !== '0) begin
            failures++;
            $display("FAIL reset_state dut%0d got=%h exp=0", k, obs[k]);
         end
      end
      start = 1'b1; gv = 1'b1; tv = 1'b1;
      cyc();
      start = 1'b0; gv = 1'b0; tv = 1'b0;
      checks++;
      if (bz_a !== 1'b0 || cc_a !== 16'd0) begin
         failures++;
         $display("FAIL reset_hold busy=%b cmp=%0d exp busy=0 cmp=0", bz_a, cc_a);
      end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_clean_stream();
      pulse_start();
      run_stream(10, 2, -1, '0, '0);
      pulse_stop();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs[k] !== expv(k)) begin
            failures++;
            $display("FAIL clean_model dut%0d got=%h exp=%h", k, obs[k], expv(k));
         end
      end
      checks++;
      if (cc_a !== 16'd10 || ec_a !== 16'd0 || ps_a !== 1'b1) begin
         failures++;
         $display("FAIL clean_t1 cmp=%0d err=%0d pass=%b exp 10 0 1", cc_a, ec_a, ps_a);
      end
   endtask

   task automatic test_first_fail();
      pulse_start();
      run_stream(8, 2, 5, 32'h0008_0000, '0);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs[k] !== expv(k)) begin
            failures++;
            $display("FAIL first_model dut%0d got=%h exp=%h", k, obs[k], expv(k));
         end
      end
      checks++;
      if (dn_a !== 1'b1 || bz_a !== 1'b0 || fc_a !== 2'd2 || fb_a !== 16'd5 ||
          ec_a !== 16'd1 || mm_a !== 4'b0100) begin
         failures++;
         $display("FAIL first_t2 done=%b busy=%b fch=%0d fbeat=%0d errc=%0d mm=%b exp 1 0 2 5 1 0100",
                  dn_a, bz_a, fc_a, fb_a, ec_a, mm_a);
      end
   endtask

   task automatic test_care_mask();
      pulse_start();
      run_stream(8, 2, 5, 32'h0008_0000, 32'h0008_0000);
      pulse_stop();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs[k] !== expv(k)) begin
            failures++;
            $display("FAIL care_model dut%0d got=%h exp=%h", k, obs[k], expv(k));
         end
      end
      checks++;
      if (ps_a !== 1'b1 || ec_a !== 16'd0 || cc_a !== 16'd8) begin
         failures++;
         $display("FAIL care_t3 pass=%b errc=%0d cmp=%0d exp 1 0 8", ps_a, ec_a, cc_a);
      end
      pulse_start();
      run_stream(4, 2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      pulse_stop();
      checks++;
      if (ps_b !== 1'b1 || cc_b !== 16'd4) begin
         failures++;
         $display("FAIL care_zero pass=%b cmp=%0d exp 1 4", ps_b, cc_b);
      end
   endtask

   task automatic test_multi_channel();
      pulse_start();
      run_stream(8, 2, 3, 32'h0100_0100, '0);
      pulse_stop();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs[k] !== expv(k)) begin
            failures++;
            $display("FAIL multi_model dut%0d got=%h exp=%h", k, obs[k], expv(k));
         end
      end
      checks++;
      if (fc_b !== 2'd1 || ec_b !== 16'd1 || cc_b !== 16'd8 || mm_b !== 4'b0000 || ps_b !== 1'b0) begin
         failures++;
         $display("FAIL multi_t4 fch=%0d errc=%0d cmp=%0d mm=%b pass=%b exp 1 1 8 0000 0",
                  fc_b, ec_b, cc_b, mm_b, ps_b);
      end
   endtask

   task automatic test_align();
      pulse_start();
      run_stream(6, 1, -1, '0, '0);
      pulse_stop();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs[k] !== expv(k)) begin
            failures++;
            $display("FAIL align_model dut%0d got=%h exp=%h", k, obs[k], expv(k));
         end
      end
      checks++;
      if (al_b !== 1'b1 || er_b !== 1'b1 || dn_b !== 1'b1 || ps_b !== 1'b0 || fc_b !== 2'd0 ||
          al_a !== 1'b1 || ps_a !== 1'b0) begin
         failures++;
         $display("FAIL align_t5 b:al=%b err=%b done=%b pass=%b fch=%0d a:al=%b pass=%b exp 1 1 1 0 0 1 0",
                  al_b, er_b, dn_b, ps_b, fc_b, al_a, ps_a);
      end
   endtask

   task automatic test_saturate_and_reset();
      pulse_start();
      run_stream(20, 2, -1, '0, '0);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs[k] !== expv(k)) begin
            failures++;
            $display("FAIL sat_model dut%0d got=%h exp=%h", k, obs[k], expv(k));
         end
      end
      checks++;
      if (cc_c !== 4'd15 || cc_a !== 16'd20 || bz_c !== 1'b1) begin
         failures++;
         $display("FAIL sat_t6 cmp_c=%0d cmp_a=%0d busy_c=%b exp 15 20 1", cc_c, cc_a, bz_c);
      end
      pulse_start();
      gv = 1'b1; gd = 32'hDEAD_BEEF; gm = '1;
      cyc();
      rst = 1'b0; gv = 1'b0;
      #2;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs[k] !== '0) begin
            failures++;
            $display("FAIL midreset dut%0d got=%h exp=0", k, obs[k]);
         end
      end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_back_to_back();
      pulse_start();
      run_stream(3, 2, -1, '0, '0);
      pulse_start();
      checks++;
      if (cc_a !== 16'd0 || bz_a !== 1'b1) begin
         failures++;
         $display("FAIL restart cmp=%0d busy=%b exp 0 1", cc_a, bz_a);
      end
      run_stream(4, 2, 0, 32'h0000_0001, '0);
      start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs[k] !== expv(k)) begin
            failures++;
            $display("FAIL b2b_model dut%0d got=%h exp=%h", k, obs[k], expv(k));
         end
      end
      checks++;
      if (bz_b !== 1'b1 || er_b !== 1'b0 || cc_b !== 16'd0) begin
         failures++;
         $display("FAIL start_stop busy=%b err=%b cmp=%0d exp 1 0 0", bz_b, er_b, cc_b);
      end
   endtask

   task automatic test_random();
      bit pv [2];
      logic [DW-1:0] pd [2];
      pv[0] = 1'b0; pv[1] = 1'b0; pd[0] = '0; pd[1] = '0;
      pulse_start();
      for (int i = 0; i < 600; i++) begin
         start = ($urandom_range(0, 99) < 2);
         stop  = ($urandom_range(0, 99) < 2);
         tv = pv[1] ^ ($urandom_range(0, 99) < 2);
         td = pd[1];
         if ($urandom_range(0, 99) < 6) td = td ^ (32'h1 << $urandom_range(0, 31));
         gv = ($urandom_range(0, 99) < 70);
         gd = $urandom;
         gm = ($urandom_range(0, 3) == 0) ? 32'($urandom) : '1;
         pv[1] = pv[0]; pd[1] = pd[0]; pv[0] = gv; pd[0] = gd;
         cyc();
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs[k] !== expv(k)) begin
               failures++;
               $display("FAIL random cyc%0d dut%0d got=%h exp=%h", i, k, obs[k], expv(k));
            end
         end
      end
      start = 1'b0; stop = 1'b0; gv = 1'b0; tv = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean_stream();
      test_first_fail();
      test_care_mask();
      test_multi_channel();
      test_align();
      test_saturate_and_reset();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
